cache_arbiter: RTL

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/cache_arbiter.sv
// Two-requester arbiter in front of a fixed-latency cache: holds the cache in clear
// for CLEAR_CYCLES after reset, then grants one requester per cycle and routes results back.
module cache_arbiter #(
    parameter int WIDTH        = 8,
    parameter int LATENCY      = 1,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             reqA,
    input  logic [WIDTH-1:0] dataA,
    input  logic             reqB,
    input  logic [WIDTH-1:0] dataB,
    output logic             grantA,
    output logic             grantB,
    output logic             respValidA,
    output logic             respValidB,
    output logic [WIDTH-1:0] respData,
    output logic [WIDTH-1:0] cacheDataIn,
    input  logic [WIDTH-1:0] cacheDataOut,
    output logic             cacheClear,
    output logic             busy,
    output logic             state_dbg
);

    localparam logic [0:0] INIT   = 1'b0;
    localparam logic [0:0] RUN    = 1'b1;
    localparam logic       PRIO_A = 1'b0;
    localparam logic       PRIO_B = 1'b1;
    localparam int         CW     = $clog2(CLEAR_CYCLES + 1);

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] cache_data_in_q, cache_data_in_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_valid_a_q, resp_valid_a_d;
    logic             resp_valid_b_q, resp_valid_b_d;
    logic             cache_clear_q, cache_clear_d;
    logic             busy_q, busy_d;
    // Tag pipeline: bit 0 is the newest grant, bit LATENCY the one whose cache result is ready.
    logic [LATENCY:0] tag_valid_q, tag_valid_d;
    logic [LATENCY:0] tag_owner_q, tag_owner_d;
    logic             grant_a, grant_b;

    always_comb begin
        grant_a = (state_q == RUN) && reqA && (!reqB || (prio_q == PRIO_A));
        grant_b = (state_q == RUN) && reqB && (!reqA || (prio_q == PRIO_B));

        state_d         = state_q;
        cnt_d           = cnt_q;
        prio_d          = prio_q;
        cache_data_in_d = cache_data_in_q;
        resp_data_d     = resp_data_q;
        cache_clear_d   = cache_clear_q;
        busy_d          = busy_q;

        case (state_q)
            INIT: begin
                if (cnt_q == CW'(CLEAR_CYCLES - 1)) begin
                    state_d       = RUN;
                    cnt_d         = '0;
                    cache_clear_d = 1'b0;
                    busy_d        = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
            end
            default: state_d = INIT;
        endcase

        if (grant_a) begin
            cache_data_in_d = dataA;
            prio_d          = PRIO_B;
        end else if (grant_b) begin
            cache_data_in_d = dataB;
            prio_d          = PRIO_A;
        end

        tag_valid_d = {tag_valid_q[LATENCY-1:0], grant_a | grant_b};
        tag_owner_d = {tag_owner_q[LATENCY-1:0], grant_b};

        resp_valid_a_d = tag_valid_q[LATENCY] & ~tag_owner_q[LATENCY];
        resp_valid_b_d = tag_valid_q[LATENCY] &  tag_owner_q[LATENCY];
        if (tag_valid_q[LATENCY]) begin
            resp_data_d = cacheDataOut;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q         <= INIT;
            cnt_q           <= '0;
            prio_q          <= PRIO_A;
            cache_data_in_q <= '0;
            resp_data_q     <= '0;
            resp_valid_a_q  <= 1'b0;
            resp_valid_b_q  <= 1'b0;
            cache_clear_q   <= 1'b1;
            busy_q          <= 1'b1;
            tag_valid_q     <= '0;
            tag_owner_q     <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            prio_q          <= prio_d;
            cache_data_in_q <= cache_data_in_d;
            resp_data_q     <= resp_data_d;
            resp_valid_a_q  <= resp_valid_a_d;
            resp_valid_b_q  <= resp_valid_b_d;
            cache_clear_q   <= cache_clear_d;
            busy_q          <= busy_d;
            tag_valid_q     <= tag_valid_d;
            tag_owner_q     <= tag_owner_d;
        end
    end

    assign grantA      = grant_a;
    assign grantB      = grant_b;
    assign respValidA  = resp_valid_a_q;
    assign respValidB  = resp_valid_b_q;
    assign respData    = resp_data_q;
    assign cacheDataIn = cache_data_in_q;
    assign cacheClear  = cache_clear_q;
    assign busy        = busy_q;
    assign state_dbg   = state_q;

endmodule
